// File: rtl/flash_boot_pkg.sv
// Shared definitions for the flash-to-SRAM boot copier: address widths and
// the copier state encoding.
package flash_boot_pkg;

  localparam int FLASH_AW = 22;
  localparam int RAM_AW   = 20;

  // Copier states, kept as plain constants so older code can match on them.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] RD_LO = 3'd2;
  localparam logic [2:0] RD_HI = 3'd3;
  localparam logic [2:0] WR    = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

endpackage

// File: rtl/flash_boot_loader.sv
// Boot-time copier: walks the flash reader's halfword address, pairs the
// halfwords into little-endian 32-bit words and writes them to SRAM with a
// single-beat write/ack handshake. busy/done hold the CPU off until the image
// is resident.
module flash_boot_loader
  import flash_boot_pkg::*;
#(
  parameter int                  WORDS      = 1024,
  parameter logic [FLASH_AW-1:0] FLASH_BASE = 22'h000000,
  parameter logic [RAM_AW-1:0]   RAM_BASE   = 20'h00000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [FLASH_AW:1]   flash_addr,
  input  logic [15:0]         flash_data,
  input  logic                flash_ready,
  output logic                ram_we,
  output logic [RAM_AW-1:0]   ram_addr,
  output logic [31:0]         ram_wdata,
  input  logic                ram_ack,
  output logic                busy,
  output logic                done
);

  // Counter must be able to hold WORDS itself on the final increment.
  localparam int            CW   = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [2:0]        state_reg;
  logic [CW-1:0]     count_reg;
  logic [15:0]       lo_reg;
  logic [1:0][15:0]  half_pair;
  logic [31:0]       packed_word;
  logic [RAM_AW-1:0] word_addr;

  // Lower flash address lands in the low halfword of the RAM word.
  assign half_pair[0] = lo_reg;
  assign half_pair[1] = flash_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pack
      assign packed_word[gi*16 +: 16] = half_pair[gi];
    end
  endgenerate

  // RAM destination wraps modulo the SRAM address space.
  assign word_addr = RAM_BASE + RAM_AW'(count_reg);

  // Copy sequencer; reset is asynchronous so ram_we drops without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      flash_addr <= FLASH_BASE;
      count_reg  <= '0;
      lo_reg     <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= ARM;
            flash_addr <= FLASH_BASE;
            count_reg  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ARM: begin
          // The reader may have latched the previous address on the start
          // edge, so the first pulse after starting is thrown away.
          if (flash_ready) begin
            state_reg <= RD_LO;
          end
        end
        RD_LO: begin
          if (flash_ready) begin
            lo_reg     <= flash_data;
            flash_addr <= flash_addr + FLASH_AW'(1);
            state_reg  <= RD_HI;
          end
        end
        RD_HI: begin
          if (flash_ready) begin
            ram_wdata  <= packed_word;
            ram_addr   <= word_addr;
            ram_we     <= 1'b1;
            flash_addr <= flash_addr + FLASH_AW'(1);
            state_reg  <= WR;
          end
        end
        WR: begin
          // ram_we is always high here, so an ack on the rise edge (seen
          // while still in RD_HI) never counts.
          if (ram_ack) begin
            ram_we    <= 1'b0;
            count_reg <= count_reg + CW'(1);
            if (count_reg == LAST) begin
              state_reg <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state_reg <= RD_LO;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Self-checking bench for flash_boot_loader: a behavioural 6-cycle flash
// reader, an SRAM ack driver and a table of expected writes.
module tb_flash_boot_loader;

  typedef struct {
    int          ack_delay;
    logic [19:0] addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        fr = 1'b0;
  logic [15:0] fd0 = '0, fd1 = '0;
  logic [22:1] fa0, fa1;
  logic        we0, we1;
  logic [19:0] ra0, ra1;
  logic [31:0] wd0, wd1;
  logic        ack0 = 1'b1, ack1 = 1'b1;
  logic        busy0, busy1, done0, done1;
  logic        ack_idle = 1'b1;

  int rcnt = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [51:0] wq0[$];
  logic [51:0] wq1[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  flash_boot_loader #(.WORDS(2), .FLASH_BASE(22'h000000), .RAM_BASE(20'h00000)) u0 (
    .clk(clk), .rst(rst), .start(start0), .flash_addr(fa0), .flash_data(fd0),
    .flash_ready(fr), .ram_we(we0), .ram_addr(ra0), .ram_wdata(wd0),
    .ram_ack(ack0), .busy(busy0), .done(done0));

  flash_boot_loader #(.WORDS(1), .FLASH_BASE(22'h3FFFFF), .RAM_BASE(20'h00ABC)) u1 (
    .clk(clk), .rst(rst), .start(start1), .flash_addr(fa1), .flash_data(fd1),
    .flash_ready(fr), .ram_we(we1), .ram_addr(ra1), .ram_wdata(wd1),
    .ram_ack(ack1), .busy(busy1), .done(done1));

  // Flash contents: halfword at address a is its low nibble + 1, repeated.
  function automatic logic [15:0] fdata(input logic [21:0] a);
    logic [3:0] n;
    n = a[3:0] + 4'd1;
    return {4{n}};
  endfunction

  // Free-running reader: samples the address on the edge the pulse rises.
  always @(posedge clk) begin
    rcnt <= (rcnt == 5) ? 0 : rcnt + 1;
    if (rcnt == 4) begin
      fr  <= 1'b1;
      fd0 <= fdata(fa0);
      fd1 <= fdata(fa1);
    end else begin
      fr <= 1'b0;
    end
  end

  // Record every accepted SRAM write.
  always @(posedge clk) begin
    if (we0 && ack0) wq0.push_back({ra0, wd0});
    if (we1 && ack1) wq1.push_back({ra1, wd1});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for one write on u0, check it against vecs[idx], ack after the delay.
  task automatic service_write(input int idx);
    int n;
    n = 0;
    while (we0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("we_rise", we0, 1'b1);
    if (we0 !== 1'b1) return;
    check("wr_addr", ra0, vecs[idx].addr);
    check("wr_data", wd0, vecs[idx].data);
    $display("write %0d: addr=%05h data=%08h ack_delay=%0d", idx, ra0, wd0, vecs[idx].ack_delay);
    for (int k = 0; k < vecs[idx].ack_delay; k++) begin
      @(negedge clk);
      check("hold_we", we0, 1'b1);
      check("hold_addr", ra0, vecs[idx].addr);
      check("hold_data", wd0, vecs[idx].data);
    end
    ack0 = 1'b1;
    @(negedge clk);
    check("we_fall", we0, 1'b0);
    ack0 = ack_idle;
  endtask

  task automatic wait_done0(input string name);
    int n;
    n = 0;
    while (done0 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, done0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{0, 20'h00000, 32'h22221111};
    vecs[1] = '{0, 20'h00001, 32'h44443333};
    vecs[2] = '{5, 20'h00000, 32'h22221111};
    vecs[3] = '{0, 20'h00001, 32'h44443333};
    vecs[4] = '{0, 20'h00000, 32'h22221111};
    vecs[5] = '{0, 20'h00001, 32'h44443333};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_flash_addr", fa0, 22'h0);
    check("rst_flash_addr1", fa1, 22'h3FFFFF);
    check("rst_we", we0, 1'b0);
    check("rst_ram_addr", ra0, 20'h0);
    check("rst_wdata", wd0, 32'h0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: ack always high, extra start while busy must be ignored.
    ack_idle = 1'b1;
    ack0 = 1'b1;
    start0 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check("busy_rise", busy0, 1'b1);
    check("busy_rise1", busy1, 1'b1);
    check("done_low", done0, 1'b0);
    service_write(0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("busy_ignored_start", busy0, 1'b1);
    service_write(1);
    wait_done0("run1_done");
    check("run1_busy", busy0, 1'b0);
    check("run1_flash_addr", fa0, 22'h4);
    check("run1_nwrites", wq0.size(), 2);

    // Wrapped single-word copy on u1.
    n = 0;
    while (done1 !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wrap_done", done1, 1'b1);
    check("wrap_busy", busy1, 1'b0);
    check("wrap_flash_addr", fa1, 22'h000001);
    check("wrap_nwrites", wq1.size(), 1);
    check("wrap_write", (wq1.size() > 0) ? wq1[0] : 52'h0, {20'h00ABC, 32'h11110000});
    $display("wrap write: addr=%05h data=%08h", ra1, wd1);

    // Run 2: restart from DONE on the reader's sampling edge, delayed ack.
    ack_idle = 1'b0;
    ack0 = 1'b0;
    n = 0;
    while (rcnt != 4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("restart_done_clr", done0, 1'b0);
    check("restart_busy", busy0, 1'b1);
    check("restart_flash_addr", fa0, 22'h0);
    service_write(2);
    service_write(3);
    wait_done0("run2_done");
    check("run2_flash_addr", fa0, 22'h4);

    // Run 3: reset while a write is pending.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 0;
    while (we0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("run3_we_rise", we0, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_we_drop", we0, 1'b0);
    check("async_flash_addr", fa0, 22'h0);
    check("async_busy", busy0, 1'b0);
    check("async_ram_addr", ra0, 20'h0);
    check("async_wdata", wd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", done0, 1'b0);

    // Run 4: full recopy after reset.
    ack_idle = 1'b1;
    ack0 = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    service_write(4);
    service_write(5);
    wait_done0("run4_done");
    check("run4_busy", busy0, 1'b0);
    check("run4_flash_addr", fa0, 22'h4);

    // Every accepted write, in order, against the table.
    check("total_writes", wq0.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check("table_write", (wq0.size() > i) ? wq0[i] : 52'h0, {vecs[i].addr, vecs[i].data});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Boot-time copier that sits directly downstream of the flash reader. It steps the reader's halfword address, captures each halfword when the reader's ready pulse arrives, packs pairs into 32-bit little-endian words, and writes them to base SRAM through a single-beat write/ack handshake. The CPU core is held off (via `busy`/`done`) until the image is resident in RAM.

## Interface
- `WORDS`, 1024: number of 32-bit words to copy; must be ≥1.
- `FLASH_BASE`, 22'h000000: first flash halfword address, bits [22:1].
- `RAM_BASE`, 20'h00000: first SRAM word address.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle request to begin a copy; honoured only in IDLE or DONE.
- `flash_addr` out [22:1]: halfword address presented to the flash reader.
- `flash_data` in 16: halfword from the reader, already byte-swapped; valid only while `flash_ready`=1.
- `flash_ready` in 1: reader's one-cycle data-valid pulse (the reader free-runs, about 1 pulse per 6 clk).
- `ram_we` out 1: write request, held until acknowledged.
- `ram_addr` out 20: SRAM word address.
- `ram_wdata` out 32: SRAM write data.
- `ram_ack` in 1: write accepted on a clk edge where `ram_we`=1 and `ram_ack`=1.
- `busy` out 1: copy in progress.
- `done` out 1: copy complete; sticky.

## Operation
- Reset values: state IDLE; `flash_addr`=FLASH_BASE, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `done`=0; word counter and low-half register cleared. Asserting `rst` mid-copy aborts immediately and drops `ram_we` asynchronously. No partial-state recovery.
- States:
  - IDLE: `start` → ARM. Load `flash_addr`=FLASH_BASE, clear the counter, set `busy`=1.
  - ARM: the first `flash_ready` is discarded, because the reader may have sampled the old address on the same edge. → RD_LO.
  - RD_LO: on `flash_ready`, capture `lo`=`flash_data` and increment `flash_addr` → RD_HI.
  - RD_HI: on `flash_ready`, set `ram_wdata`={`flash_data`, `lo`} and `ram_addr`=RAM_BASE+count, raise `ram_we`, increment `flash_addr` → WR.
  - WR: hold `ram_we`, `ram_addr` and `ram_wdata` stable until `ram_ack`. On ack, drop `ram_we` and increment the counter. If the counter was WORDS−1 → DONE; otherwise → RD_LO.
  - DONE: `busy`=0, `done`=1. `start` clears `done` and restarts exactly as from IDLE.
- `flash_ready` pulses in IDLE, WR or DONE are ignored. The reader re-reads continuously, so nothing is lost.
- `start` while `busy` is ignored.
- `flash_addr` changes only on the edge that consumes a ready pulse (or on the start edge). It wraps modulo 2^22.
- `ram_addr` is RAM_BASE+count, modulo 2^20.
- The counter is $clog2(WORDS+1) bits wide.
- Byte order: the lower flash address supplies `ram_wdata`[15:0].

## Timing
- All outputs are registered. `busy` rises on the edge after `start`.
- Per word: 2 accepted ready pulses plus ack wait. With a 6-cycle reader and a zero-wait ack, a word takes ≤ 13 cycles. The first word adds up to 6 cycles for ARM.
- `ram_we` rises on the edge after the second ready pulse. It falls on the edge where ack is sampled.
- `done` rises on the edge after the final ack. `busy` falls on that same edge.
- An ack coincident with the `ram_we` rise edge is not counted. Ack is sampled only while `ram_we`=1.

## Structure
- Shared package `flash_boot_pkg` holds:
  - the state encoding localparams (IDLE, ARM, RD_LO, RD_HI, WR, DONE);
  - `FLASH_AW`=22 and `RAM_AW`=20.
- Single module with no sub-module. The packing logic is too small to justify one.
- The bench reuses the flash reader's 6-cycle ready cadence as a behavioural model.

## Test plan
- WORDS=2, flash[0..3]=16'h1111, 2222, 3333, 4444, ack always 1, `start` pulse → writes (0, 32'h22221111) then (1, 32'h44443333); `done`=1, `busy`=0, `flash_addr`=4.
- Ack delayed 5 cycles on word 0 → `ram_we`, `ram_addr` and `ram_wdata` stable for all 5 cycles, exactly one write; ready pulses during WR ignored; data still correct.
- `start` issued on the same edge as a reader ready pulse → that pulse is discarded in ARM; the first captured halfword comes from FLASH_BASE.
- `rst` asserted while in WR → `ram_we` drops without a clock edge; after release, outputs are at reset values and `start` recopies from FLASH_BASE.
- `start` while `busy`, then `start` in DONE → the first is ignored; the second clears `done` and repeats an identical copy.
- FLASH_BASE=22'h3FFFFF, WORDS=1 → the second halfword is read from address 0; the write goes to RAM_BASE.
